// File: rtl/ysyx_22041071_axi_rd_arb.sv
// rtl/ysyx_22041071_axi_rd_arb.sv - round-robin IFU/LSU read arbiter onto one AXI read master
// One transaction in flight; a watchdog closes a stalled burst with SLVERR.
module ysyx_22041071_axi_rd_arb #(
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 64,
   parameter int LEN_W   = 8,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ifu_req_valid,
   output logic              ifu_req_ready,
   input  logic [ADDR_W-1:0] ifu_req_addr,
   input  logic [LEN_W-1:0]  ifu_req_len,
   input  logic [1:0]        ifu_req_size,
   output logic              ifu_resp_valid,
   output logic              ifu_resp_last,
   output logic [DATA_W-1:0] ifu_resp_data,
   output logic [1:0]        ifu_resp_resp,
   input  logic              lsu_req_valid,
   output logic              lsu_req_ready,
   input  logic [ADDR_W-1:0] lsu_req_addr,
   input  logic [LEN_W-1:0]  lsu_req_len,
   input  logic [1:0]        lsu_req_size,
   output logic              lsu_resp_valid,
   output logic              lsu_resp_last,
   output logic [DATA_W-1:0] lsu_resp_data,
   output logic [1:0]        lsu_resp_resp,
   output logic              rd_req_valid,
   input  logic              rd_req_ready,
   output logic [3:0]        rd_id,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [LEN_W-1:0]  rd_len,
   output logic [1:0]        rd_size,
   input  logic              rd_beat_valid,
   input  logic              rd_beat_last,
   input  logic [DATA_W-1:0] rd_beat_data,
   input  logic [1:0]        rd_beat_resp,
   input  logic [3:0]        rd_beat_id,
   output logic              busy,
   output logic              err_id
);
   localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, REQ, DATA} state_e;

   state_e            state_q, state_d;
   logic              last_q, last_d;
   logic              owner_q, owner_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [1:0]        size_q, size_d;
   logic [WD_W-1:0]   wdog_q, wdog_d;

   logic              grant_ifu, grant_lsu, beat_hit, expire, req_valid_c;
   logic              fwd_valid, fwd_last;
   logic [DATA_W-1:0] fwd_data;
   logic [1:0]        fwd_resp;

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      owner_d     = owner_q;
      err_d       = err_q;
      addr_d      = addr_q;
      len_d       = len_q;
      size_d      = size_q;
      wdog_d      = wdog_q;
      grant_ifu   = 1'b0;
      grant_lsu   = 1'b0;
      beat_hit    = 1'b0;
      expire      = 1'b0;
      req_valid_c = 1'b0;
      case (state_q)
         IDLE: begin
            // last_q=1 means LSU was granted last, so IFU wins a tie
            if (ifu_req_valid && (!lsu_req_valid || last_q)) grant_ifu = 1'b1;
            else if (lsu_req_valid)                         grant_lsu = 1'b1;
            if (grant_ifu || grant_lsu) begin
               owner_d = grant_lsu;
               last_d  = grant_lsu;
               addr_d  = grant_lsu ? lsu_req_addr : ifu_req_addr;
               len_d   = grant_lsu ? lsu_req_len  : ifu_req_len;
               size_d  = grant_lsu ? lsu_req_size : ifu_req_size;
               state_d = REQ;
            end
         end
         REQ: begin
            req_valid_c = 1'b1;
            if (rd_req_ready) begin
               state_d = DATA;
               wdog_d  = '0;
            end
         end
         DATA: begin
            beat_hit = rd_beat_valid && (rd_beat_id == {3'b000, owner_q});
            if (rd_beat_valid && !beat_hit) err_d = 1'b1;
            if (beat_hit) begin
               wdog_d = '0;
               if (rd_beat_last) state_d = IDLE;
            end else if (wdog_q == WD_W'(TIMEOUT)) begin
               expire  = 1'b1;
               wdog_d  = '0;
               state_d = IDLE;
            end else begin
               wdog_d = wdog_q + WD_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         last_q  <= 1'b0;
         owner_q <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         len_q   <= '0;
         size_q  <= '0;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         size_q  <= size_d;
         wdog_q  <= wdog_d;
      end
   end

   // Combinational outputs are masked during reset so a mid-burst reset is silent at once
   assign fwd_valid = (beat_hit || expire) && !reset;
   assign fwd_last  = beat_hit ? rd_beat_last : 1'b1;
   assign fwd_data  = beat_hit ? rd_beat_data : '0;
   assign fwd_resp  = beat_hit ? rd_beat_resp : 2'b10;

   assign ifu_req_ready  = grant_ifu && !reset;
   assign lsu_req_ready  = grant_lsu && !reset;
   assign ifu_resp_valid = fwd_valid && !owner_q;
   assign lsu_resp_valid = fwd_valid && owner_q;
   assign ifu_resp_last  = ifu_resp_valid && fwd_last;
   assign lsu_resp_last  = lsu_resp_valid && fwd_last;
   assign ifu_resp_data  = ifu_resp_valid ? fwd_data : '0;
   assign lsu_resp_data  = lsu_resp_valid ? fwd_data : '0;
   assign ifu_resp_resp  = ifu_resp_valid ? fwd_resp : 2'b00;
   assign lsu_resp_resp  = lsu_resp_valid ? fwd_resp : 2'b00;

   assign rd_req_valid = req_valid_c && !reset;
   assign rd_id        = {3'b000, owner_q};
   assign rd_addr      = addr_q;
   assign rd_len       = len_q;
   assign rd_size      = size_q;
   assign busy         = (state_q != IDLE) && !reset;
   assign err_id       = err_q;
endmodule
